// File: rtl/mem_write_checker.sv
// Write-port monitor: releases CPU start after a delay, matches data-memory writes
// against an expected (address, data) table and reports pass/fail with a cause code.
module mem_write_checker #(
  parameter int unsigned                   ADDR_W         = 32,
  parameter int unsigned                   DATA_W         = 32,
  parameter int unsigned                   NUM_CHECKS     = 2,
  parameter logic [NUM_CHECKS*ADDR_W-1:0]  EXP_ADDR       = {32'd100, 32'd100},
  parameter logic [NUM_CHECKS*DATA_W-1:0]  EXP_DATA       = {32'd7, 32'd7},
  parameter bit                            ORDERED        = 1'b1,
  parameter bit                            STRICT         = 1'b1,
  parameter logic [ADDR_W-1:0]             IGN_LO         = ADDR_W'(96),
  parameter logic [ADDR_W-1:0]             IGN_HI         = ADDR_W'(96),
  parameter int unsigned                   START_DELAY    = 3,
  parameter int unsigned                   TIMEOUT_CYCLES = 50000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              MemWrite,
  input  logic [ADDR_W-1:0]                 DataAdr,
  input  logic [DATA_W-1:0]                 WriteData,
  output logic                              start,
  output logic                              done,
  output logic                              pass,
  output logic                              fail,
  output logic [1:0]                        fail_code,
  output logic [$clog2(NUM_CHECKS+1)-1:0]   hit_count,
  output logic [31:0]                       cycle_count
);

  localparam int unsigned HC_W     = $clog2(NUM_CHECKS + 1);
  localparam int unsigned DLY_LAST = (START_DELAY == 0) ? 0 : START_DELAY - 1;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_DATA    = 2'd1;
  localparam logic [1:0] FC_ADDR    = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {S_DELAY, S_RUN, S_PASS, S_FAIL} state_t;

  state_t                  r_state, w_state_nxt;
  logic [31:0]             r_dly, w_dly_nxt;
  logic [NUM_CHECKS-1:0]   r_hit_mask, w_mask_nxt;
  logic [HC_W-1:0]         r_hit_count, w_hit_nxt;
  logic [31:0]             r_cycle_count, w_cyc_nxt;
  logic [1:0]              r_fail_code, w_code_nxt;
  logic                    r_start, r_done, r_pass, r_fail;

  logic                    w_in_ign, w_any_addr, w_ord_addr_eq, w_ord_data_eq;
  logic                    w_un_found, w_un_data_eq;
  logic [NUM_CHECKS-1:0]   w_un_sel;
  logic                    w_hit, w_bad;
  logic [1:0]              w_bad_code;

  // Classify the current write against the table
  always_comb begin
    w_in_ign      = (DataAdr >= IGN_LO) && (DataAdr <= IGN_HI);
    w_any_addr    = 1'b0;
    w_ord_addr_eq = 1'b0;
    w_ord_data_eq = 1'b0;
    w_un_found    = 1'b0;
    w_un_data_eq  = 1'b0;
    w_un_sel      = '0;
    for (int i = 0; i < int'(NUM_CHECKS); i++) begin
      if (EXP_ADDR[i*ADDR_W +: ADDR_W] == DataAdr) w_any_addr = 1'b1;
      if (HC_W'(i) == r_hit_count) begin
        w_ord_addr_eq = (EXP_ADDR[i*ADDR_W +: ADDR_W] == DataAdr);
        w_ord_data_eq = (EXP_DATA[i*DATA_W +: DATA_W] == WriteData);
      end
      if (!w_un_found && !r_hit_mask[i] && (EXP_ADDR[i*ADDR_W +: ADDR_W] == DataAdr)) begin
        w_un_found   = 1'b1;
        w_un_sel[i]  = 1'b1;
        w_un_data_eq = (EXP_DATA[i*DATA_W +: DATA_W] == WriteData);
      end
    end

    w_hit      = 1'b0;
    w_bad      = 1'b0;
    w_bad_code = FC_NONE;
    if (MemWrite && !w_in_ign) begin
      if (ORDERED) begin
        if (w_ord_addr_eq) begin
          if (w_ord_data_eq) w_hit = 1'b1;
          else begin w_bad = 1'b1; w_bad_code = FC_DATA; end
        end else if (w_any_addr || STRICT) begin
          w_bad      = 1'b1;
          w_bad_code = FC_ADDR;
        end
      end else begin
        if (w_un_found) begin
          if (w_un_data_eq) w_hit = 1'b1;
          else begin w_bad = 1'b1; w_bad_code = FC_DATA; end
        end else if (STRICT) begin
          w_bad      = 1'b1;
          w_bad_code = FC_ADDR;
        end
      end
    end
  end

  // Next-state logic; a completing hit outranks a same-edge timeout
  always_comb begin
    w_state_nxt = r_state;
    w_dly_nxt   = r_dly;
    w_mask_nxt  = r_hit_mask;
    w_hit_nxt   = r_hit_count;
    w_cyc_nxt   = r_cycle_count;
    w_code_nxt  = r_fail_code;
    case (r_state)
      S_DELAY: begin
        w_dly_nxt = r_dly + 32'd1;
        if (r_dly >= 32'(DLY_LAST)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_cyc_nxt = (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + 32'd1;
        if (w_hit) begin
          if (!ORDERED) w_mask_nxt = r_hit_mask | w_un_sel;
          if (r_hit_count != HC_W'(NUM_CHECKS)) w_hit_nxt = r_hit_count + HC_W'(1);
        end
        if (w_hit && (w_hit_nxt == HC_W'(NUM_CHECKS))) begin
          w_state_nxt = S_PASS;
        end else if (w_bad) begin
          w_state_nxt = S_FAIL;
          w_code_nxt  = w_bad_code;
        end else if (w_cyc_nxt >= 32'(TIMEOUT_CYCLES)) begin
          w_state_nxt = S_FAIL;
          w_code_nxt  = FC_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_DELAY;
      r_dly         <= '0;
      r_hit_mask    <= '0;
      r_hit_count   <= '0;
      r_cycle_count <= '0;
      r_fail_code   <= FC_NONE;
      r_start       <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_dly         <= w_dly_nxt;
      r_hit_mask    <= w_mask_nxt;
      r_hit_count   <= w_hit_nxt;
      r_cycle_count <= w_cyc_nxt;
      r_fail_code   <= w_code_nxt;
      r_start       <= (w_state_nxt != S_DELAY);
      r_done        <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL);
      r_pass        <= (w_state_nxt == S_PASS);
      r_fail        <= (w_state_nxt == S_FAIL);
    end
  end

  assign start       = r_start;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign fail_code   = r_fail_code;
  assign hit_count   = r_hit_count;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: several parameterisations share one
// write bus; each scenario resets all of them and checks the relevant instance.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // d: defaults, o: two-entry ordered, u: two-entry unordered,
  // n: defaults non-strict, t: 20-cycle timeout, z: no start delay
  logic d_start, d_done, d_pass, d_fail; logic [1:0] d_code, d_hit; logic [31:0] d_cyc;
  logic o_start, o_done, o_pass, o_fail; logic [1:0] o_code, o_hit; logic [31:0] o_cyc;
  logic u_start, u_done, u_pass, u_fail; logic [1:0] u_code, u_hit; logic [31:0] u_cyc;
  logic n_start, n_done, n_pass, n_fail; logic [1:0] n_code, n_hit; logic [31:0] n_cyc;
  logic t_start, t_done, t_pass, t_fail; logic [1:0] t_code, t_hit; logic [31:0] t_cyc;
  logic z_start, z_done, z_pass, z_fail; logic [1:0] z_code, z_hit; logic [31:0] z_cyc;

  mem_write_checker u_d (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .start(d_start), .done(d_done), .pass(d_pass), .fail(d_fail),
    .fail_code(d_code), .hit_count(d_hit), .cycle_count(d_cyc));

  mem_write_checker #(.EXP_ADDR({32'd104, 32'd100}), .EXP_DATA({32'd9, 32'd7}), .ORDERED(1'b1)) u_o (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .start(o_start), .done(o_done), .pass(o_pass), .fail(o_fail),
    .fail_code(o_code), .hit_count(o_hit), .cycle_count(o_cyc));

  mem_write_checker #(.EXP_ADDR({32'd104, 32'd100}), .EXP_DATA({32'd9, 32'd7}), .ORDERED(1'b0)) u_u (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .start(u_start), .done(u_done), .pass(u_pass), .fail(u_fail),
    .fail_code(u_code), .hit_count(u_hit), .cycle_count(u_cyc));

  mem_write_checker #(.STRICT(1'b0)) u_n (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .start(n_start), .done(n_done), .pass(n_pass), .fail(n_fail),
    .fail_code(n_code), .hit_count(n_hit), .cycle_count(n_cyc));

  mem_write_checker #(.TIMEOUT_CYCLES(20)) u_t (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .start(t_start), .done(t_done), .pass(t_pass), .fail(t_fail),
    .fail_code(t_code), .hit_count(t_hit), .cycle_count(t_cyc));

  mem_write_checker #(.START_DELAY(0)) u_z (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .start(z_start), .done(z_done), .pass(z_pass), .fail(z_fail),
    .fail_code(z_code), .hit_count(z_hit), .cycle_count(z_cyc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    tick();
    MemWrite  = 1'b0;
  endtask

  // One reset edge, then three edges so the default-delay instances are in RUN
  task automatic restart();
    reset    = 1'b1;
    MemWrite = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    // Reset values and start sequencing
    reset = 1'b1;
    tick(); tick();
    chk("rst_start", 32'(d_start), 0);
    chk("rst_done",  32'(d_done), 0);
    chk("rst_pass",  32'(d_pass), 0);
    chk("rst_fail",  32'(d_fail), 0);
    chk("rst_code",  32'(d_code), 0);
    chk("rst_hit",   32'(d_hit), 0);
    chk("rst_cyc",   d_cyc, 0);
    reset = 1'b0;
    tick();
    chk("z_start_1", 32'(z_start), 1);
    chk("d_start_1", 32'(d_start), 0);
    tick();
    chk("d_start_2", 32'(d_start), 0);
    tick();
    chk("d_start_3", 32'(d_start), 1);
    chk("d_cyc_0",   d_cyc, 0);

    // Ignore window, then two matching writes
    wr(32'd96, 32'd5);
    chk("ign_hit",  32'(d_hit), 0);
    chk("ign_done", 32'(d_done), 0);
    chk("ign_cyc",  d_cyc, 1);
    wr(32'd100, 32'd7);
    chk("hit1_cnt",  32'(d_hit), 1);
    chk("hit1_done", 32'(d_done), 0);
    chk("o_hit1",    32'(o_hit), 1);
    chk("u_hit1",    32'(u_hit), 1);
    wr(32'd100, 32'd7);
    chk("pass",      32'(d_pass), 1);
    chk("pass_done", 32'(d_done), 1);
    chk("pass_code", 32'(d_code), 0);
    chk("pass_hit",  32'(d_hit), 2);
    chk("pass_cyc",  d_cyc, 3);
    chk("o_reorder_fail", 32'(o_fail), 1);
    chk("o_reorder_code", 32'(o_code), 2);
    chk("u_rehit_fail",   32'(u_fail), 1);
    chk("u_rehit_code",   32'(u_code), 2);
    wr(32'd100, 32'd6);
    tick();
    chk("sticky_pass", 32'(d_pass), 1);
    chk("sticky_fail", 32'(d_fail), 0);
    chk("sticky_hit",  32'(d_hit), 2);
    chk("sticky_cyc",  d_cyc, 3);

    // Data mismatch
    restart();
    wr(32'd100, 32'd6);
    chk("mis_fail", 32'(d_fail), 1);
    chk("mis_code", 32'(d_code), 1);
    chk("mis_hit",  32'(d_hit), 0);
    chk("mis_pass", 32'(d_pass), 0);
    chk("n_mis_code", 32'(n_code), 1);

    // Ordered vs unordered table
    restart();
    wr(32'd104, 32'd9);
    chk("o_order_fail", 32'(o_fail), 1);
    chk("o_order_code", 32'(o_code), 2);
    chk("u_any_hit",    32'(u_hit), 1);
    chk("u_any_done",   32'(u_done), 0);
    wr(32'd100, 32'd7);
    chk("u_any_pass", 32'(u_pass), 1);
    chk("u_any_code", 32'(u_code), 0);

    // Strict vs non-strict unknown address
    restart();
    wr(32'd200, 32'd1);
    chk("strict_fail", 32'(d_fail), 1);
    chk("strict_code", 32'(d_code), 2);
    chk("loose_fail",  32'(n_fail), 0);
    chk("loose_done",  32'(n_done), 0);
    wr(32'd100, 32'd7);
    wr(32'd100, 32'd7);
    chk("loose_pass", 32'(n_pass), 1);
    chk("loose_hit",  32'(n_hit), 2);

    // Timeout with no writes
    restart();
    repeat (19) tick();
    chk("to_pre_fail", 32'(t_fail), 0);
    chk("to_pre_cyc",  t_cyc, 19);
    tick();
    chk("to_fail", 32'(t_fail), 1);
    chk("to_code", 32'(t_code), 3);
    chk("to_cyc",  t_cyc, 20);
    chk("to_done", 32'(t_done), 1);
    repeat (3) tick();
    chk("to_frozen", t_cyc, 20);

    // Final hit on the timeout edge wins
    restart();
    repeat (4) tick();
    wr(32'd100, 32'd7);
    chk("tw_hit1", 32'(t_hit), 1);
    repeat (14) tick();
    chk("tw_pre_cyc",  t_cyc, 19);
    chk("tw_pre_done", 32'(t_done), 0);
    wr(32'd100, 32'd7);
    chk("tw_pass", 32'(t_pass), 1);
    chk("tw_fail", 32'(t_fail), 0);
    chk("tw_cyc",  t_cyc, 20);

    // Reset in the middle of RUN
    restart();
    wr(32'd100, 32'd7);
    chk("mid_hit", 32'(d_hit), 1);
    reset = 1'b1;
    tick();
    chk("mid_start", 32'(d_start), 0);
    chk("mid_done",  32'(d_done), 0);
    chk("mid_pass",  32'(d_pass), 0);
    chk("mid_fail",  32'(d_fail), 0);
    chk("mid_code",  32'(d_code), 0);
    chk("mid_hit0",  32'(d_hit), 0);
    chk("mid_cyc",   d_cyc, 0);
    reset = 1'b0;
    repeat (3) tick();
    chk("mid_restart", 32'(d_start), 1);
    wr(32'd100, 32'd7);
    wr(32'd100, 32'd7);
    chk("mid_pass2", 32'(d_pass), 1);
    chk("mid_hit2",  32'(d_hit), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
